// File: rtl/flash_loader_pkg.sv
// rtl/flash_loader_pkg.sv - shared constants, state type and helpers for the flash ROM loader
package flash_loader_pkg;

  localparam logic [7:0]  FLASH_CMD_READ = 8'h03;
  localparam logic [23:0] FLASH_BASE_DEF = 24'h200000;
  localparam int unsigned SLOT_BYTES_DEF = 16384;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_HOLD
  } loader_state_e;

  // Image length in bytes: 2K, 4K, 8K or 16K.
  function automatic logic [14:0] len_decode(input logic [1:0] len_sel);
    return 15'd2048 << len_sel;
  endfunction

  // Flash byte address of an image slot, wrapping within the 24-bit flash space.
  function automatic logic [23:0] slot_addr(input logic [23:0] base,
                                            input logic [3:0] slot,
                                            input int unsigned stride);
    logic [31:0] sum;
    sum = {8'd0, base} + {28'd0, slot} * stride;
    return sum[23:0];
  endfunction

endpackage

// File: rtl/flash_spi_phy.sv
// rtl/flash_spi_phy.sv - SPI mode-0 clock divider with 32-bit shift-out and 8-bit shift-in
module flash_spi_phy #(
  parameter int unsigned C_HALF = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_word_i,
  input  logic        run_i,
  input  logic        miso_i,
  output logic        sck_o,
  output logic        mosi_o,
  output logic        bit_done_o,
  output logic        byte_done_o,
  output logic [7:0]  rx_byte_o
);

  localparam int unsigned HW = (C_HALF > 1) ? $clog2(C_HALF) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(C_HALF - 1);

  logic [HW-1:0] half_cnt_q;
  logic          sck_q;
  logic [31:0]   tx_q;
  logic [7:0]    rx_q;
  logic [2:0]    bit_cnt_q;
  logic          bit_done_q;
  logic          byte_done_q;

  always_ff @(posedge clk_sys) begin
    bit_done_q  <= 1'b0;
    byte_done_q <= 1'b0;
    if (reset) begin
      half_cnt_q <= '0;
      sck_q      <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
    end else if (load_i) begin
      half_cnt_q <= '0;
      sck_q      <= 1'b0;
      tx_q       <= load_word_i;
      bit_cnt_q  <= '0;
    end else if (!run_i) begin
      half_cnt_q <= '0;
    end else if (half_cnt_q == HALF_LAST) begin
      half_cnt_q <= '0;
      sck_q      <= ~sck_q;
      if (!sck_q) begin
        // Rising edge: sample MISO; MOSI is only advanced on the falling edge.
        rx_q        <= {rx_q[6:0], miso_i};
        bit_cnt_q   <= bit_cnt_q + 3'd1;
        bit_done_q  <= 1'b1;
        byte_done_q <= (bit_cnt_q == 3'd7);
      end else begin
        tx_q <= {tx_q[30:0], 1'b0};
      end
    end else begin
      half_cnt_q <= half_cnt_q + 1'b1;
    end
  end

  assign sck_o       = sck_q;
  assign mosi_o      = tx_q[31];
  assign bit_done_o  = bit_done_q;
  assign byte_done_o = byte_done_q;
  assign rx_byte_o   = rx_q;

endmodule

// File: rtl/flash_rom_loader.sv
// rtl/flash_rom_loader.sv - reads a ROM image from SPI flash and streams it into the cartridge ROM write port
module flash_rom_loader
  import flash_loader_pkg::*;
#(
  parameter logic [23:0] C_FLASH_BASE = FLASH_BASE_DEF,
  parameter int unsigned C_SLOT_BYTES = SLOT_BYTES_DEF,
  parameter int unsigned C_HALF       = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  slot,
  input  logic [1:0]  len_sel,
  output logic        flash_csn,
  output logic        flash_sck,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic        wr,
  output logic [31:0] addr,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done
);

  localparam int unsigned HW = (C_HALF > 1) ? $clog2(C_HALF) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(C_HALF - 1);

  loader_state_e state_q;
  logic          csn_q;
  logic          busy_q;
  logic          wr_q;
  logic          done_q;
  logic [13:0]   addr_q;
  logic [7:0]    data_q;
  logic [13:0]   idx_q;
  logic [13:0]   last_q;
  logic [4:0]    cmd_bits_q;
  logic [HW-1:0] hold_cnt_q;

  logic          phy_load;
  logic          phy_run;
  logic          sck;
  logic          bit_done;
  logic          byte_done;
  logic [7:0]    rx_byte;

  assign phy_load = (state_q == ST_IDLE) && start;
  // SCK keeps running into HOLD until the last bit's falling edge has happened.
  assign phy_run  = (state_q == ST_CMD) || (state_q == ST_DATA) || ((state_q == ST_HOLD) && sck);

  flash_spi_phy #(
    .C_HALF(C_HALF)
  ) u_phy (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .load_i     (phy_load),
    .load_word_i({FLASH_CMD_READ, slot_addr(C_FLASH_BASE, slot, C_SLOT_BYTES)}),
    .run_i      (phy_run),
    .miso_i     (flash_miso),
    .sck_o      (sck),
    .mosi_o     (flash_mosi),
    .bit_done_o (bit_done),
    .byte_done_o(byte_done),
    .rx_byte_o  (rx_byte)
  );

  // done lands exactly at T+1+(32+8*len)*2*C_HALF+C_HALF after the start cycle T.
  always_ff @(posedge clk_sys) begin
    wr_q   <= 1'b0;
    done_q <= 1'b0;
    if (reset) begin
      state_q    <= ST_IDLE;
      csn_q      <= 1'b1;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      cmd_bits_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            last_q     <= 14'(len_decode(len_sel) - 15'd1);
            idx_q      <= '0;
            cmd_bits_q <= '0;
            hold_cnt_q <= '0;
            csn_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (bit_done) begin
            cmd_bits_q <= cmd_bits_q + 5'd1;
            if (cmd_bits_q == 5'd31) state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (byte_done) begin
            wr_q   <= 1'b1;
            data_q <= rx_byte;
            addr_q <= idx_q;
            if (idx_q == last_q) state_q <= ST_HOLD;
            else                 idx_q   <= idx_q + 14'd1;
          end
        end
        ST_HOLD: begin
          if (!sck) begin
            if (hold_cnt_q == HOLD_LAST) begin
              csn_q   <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign flash_csn = csn_q;
  assign flash_sck = sck;
  assign wr        = wr_q;
  assign addr      = {18'd0, addr_q};
  assign data_out  = data_q;
  assign busy      = busy_q;
  assign cpu_hold  = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_flash_rom_loader.sv
// tb/tb_flash_rom_loader.sv - directed bench with SPI flash model and write scoreboard
module tb_flash_rom_loader;

  localparam int HALF = 2;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset = 1'b1, start = 1'b0;
  logic [3:0]  slot = '0;
  logic [1:0]  len_sel = '0;
  logic        flash_csn, flash_sck, flash_mosi, flash_miso = 1'b0;
  logic        wr, busy, cpu_hold, done;
  logic [31:0] addr;
  logic [7:0]  data_out;

  logic        start_w = 1'b0;
  logic [3:0]  slot_w = '0;
  logic [1:0]  len_w = '0;
  logic        w_csn, w_sck, w_mosi, w_wr, w_busy, w_hold, w_done;
  logic        w_miso = 1'b0;
  logic [31:0] w_addr;
  logic [7:0]  w_data;

  flash_rom_loader #(.C_HALF(HALF)) u_dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .slot(slot), .len_sel(len_sel),
    .flash_csn(flash_csn), .flash_sck(flash_sck), .flash_mosi(flash_mosi), .flash_miso(flash_miso),
    .wr(wr), .addr(addr), .data_out(data_out), .busy(busy), .cpu_hold(cpu_hold), .done(done)
  );

  flash_rom_loader #(.C_FLASH_BASE(24'hFF0000), .C_HALF(1)) u_wrap (
    .clk_sys(clk_sys), .reset(reset), .start(start_w), .slot(slot_w), .len_sel(len_w),
    .flash_csn(w_csn), .flash_sck(w_sck), .flash_mosi(w_mosi), .flash_miso(w_miso),
    .wr(w_wr), .addr(w_addr), .data_out(w_data), .busy(w_busy), .cpu_hold(w_hold), .done(w_done)
  );

  int checks = 0, errors = 0;
  int cyc = 0, wr_cnt = 0, done_cnt = 0, hold_bad = 0, mosi_viol = 0;
  logic [39:0] sb[$];
  logic [39:0] exp_wr;
  logic        mosi_at_rise = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  // Flash contents: 0x00..0xFF repeating, tagged by slot bits so slots differ.
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    return a[7:0] ^ {a[17:14], 4'b0000};
  endfunction

  function automatic logic fbit(input logic [23:0] a, input int j);
    logic [7:0] b;
    b = fbyte(a + 24'(j / 8));
    return b[7 - (j % 8)];
  endfunction

  int          m_cnt = 0, w_cnt = 0;
  logic [31:0] m_cmd = '0, w_cmd = '0;

  always @(posedge flash_sck or posedge flash_csn) begin
    if (flash_csn) m_cnt <= 0;
    else begin
      if (m_cnt < 32) m_cmd <= {m_cmd[30:0], flash_mosi};
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge flash_sck)
    if (flash_csn === 1'b0 && m_cnt >= 32) flash_miso <= fbit(m_cmd[23:0], m_cnt - 32);

  always @(posedge w_sck or posedge w_csn) begin
    if (w_csn) w_cnt <= 0;
    else begin
      if (w_cnt < 32) w_cmd <= {w_cmd[30:0], w_mosi};
      w_cnt <= w_cnt + 1;
    end
  end

  always @(posedge flash_sck) mosi_at_rise <= flash_mosi;

  always @(negedge clk_sys) begin
    if (wr === 1'b1) begin
      wr_cnt <= wr_cnt + 1;
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_wr = sb.pop_front();
        check("wr_addr_data", {24'd0, addr, data_out}, {24'd0, exp_wr});
      end
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (cpu_hold !== busy) hold_bad <= hold_bad + 1;
    if (flash_sck === 1'b1 && flash_mosi !== mosi_at_rise) mosi_viol <= mosi_viol + 1;
  end

  initial begin
    int n, t0, w0, d0, bad;

    repeat (3) tick();
    check("rst_ctrl", {flash_csn, flash_sck, flash_mosi, wr, busy, cpu_hold, done}, 7'b1000000);
    check("rst_addr", addr, 32'd0);
    check("rst_data", data_out, 8'd0);
    reset = 1'b0;

    bad = 0;
    repeat (100) begin
      tick();
      if (flash_csn !== 1'b1 || flash_sck !== 1'b0 || wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
        bad++;
    end
    check("idle_quiet", bad, 0);

    // Slot 15 from base 0xFF0000 wraps past the top of the flash.
    slot_w = 4'd15; start_w = 1'b1; tick(); start_w = 1'b0;
    n = 0;
    while (w_cnt < 32 && n < 200) begin tick(); n++; end
    check("wrap_cmd_timeout", 64'(n < 200), 64'd1);
    check("wrap_cmd", w_cmd, 32'h0302C000);
    reset = 1'b1; tick(); reset = 1'b0;
    check("wrap_reset", {w_csn, w_busy}, 2'b10);

    // Full 2K load from slot 0.
    for (int i = 0; i < 2048; i++) sb.push_back({32'(i), fbyte(24'h200000 + 24'(i))});
    w0 = wr_cnt; d0 = done_cnt;
    slot = 4'd0; len_sel = 2'd0; start = 1'b1; t0 = cyc; tick(); start = 1'b0;
    check("a_first_cycle", {busy, cpu_hold, flash_csn, flash_mosi, flash_sck}, 5'b11000);
    tick();
    check("a_sck_low_t2", flash_sck, 1'b0);
    tick();
    check("a_sck_high_t3", flash_sck, 1'b1);
    n = 0;
    while (m_cnt < 32 && n < 300) begin tick(); n++; end
    check("a_cmd", m_cmd, 32'h03200000);
    n = 0;
    while (done !== 1'b1 && n < 70000) begin tick(); n++; end
    check("a_done_timeout", 64'(n < 70000), 64'd1);
    check("a_done_cycle", cyc - t0, 1 + (32 + 8 * 2048) * 2 * HALF + HALF);
    tick();
    check("a_after_done", {done, busy, flash_csn, flash_sck}, 4'b0010);
    check("a_wr_count", wr_cnt - w0, 2048);
    check("a_sb_empty", sb.size(), 0);
    check("a_done_once", done_cnt - d0, 1);
    check("a_cpu_hold", hold_bad, 0);
    check("a_mosi_stable", mosi_viol, 0);

    // 16K from slot 3, with an ignored start mid-load, then reset.
    for (int i = 0; i < 16384; i++) sb.push_back({32'(i), fbyte(24'h20C000 + 24'(i))});
    w0 = wr_cnt;
    slot = 4'd3; len_sel = 2'd3; start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (m_cnt < 32 && n < 300) begin tick(); n++; end
    check("b_cmd", m_cmd, 32'h0320C000);
    n = 0;
    while (wr_cnt - w0 < 20 && n < 2000) begin tick(); n++; end
    slot = 4'd5; len_sel = 2'd0; start = 1'b1; tick(); start = 1'b0;
    check("b_still_busy", {busy, cpu_hold}, 2'b11);
    n = 0;
    while (wr_cnt - w0 < 100 && n < 5000) begin tick(); n++; end
    check("b_100_timeout", 64'(n < 5000), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("b_reset_next", {flash_csn, busy, flash_sck, wr, done}, 5'b10000);
    sb.delete();
    w0 = wr_cnt; d0 = done_cnt;
    repeat (200) tick();
    check("b_no_wr_after_reset", wr_cnt - w0, 0);
    check("b_no_done_after_reset", done_cnt - d0, 0);
    check("b_cpu_hold", hold_bad, 0);

    // Fresh start after reset restarts at address 0.
    for (int i = 0; i < 2048; i++) sb.push_back({32'(i), fbyte(24'h204000 + 24'(i))});
    w0 = wr_cnt;
    slot = 4'd1; len_sel = 2'd0; start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (m_cnt < 32 && n < 300) begin tick(); n++; end
    check("c_cmd", m_cmd, 32'h03204000);
    n = 0;
    while (wr_cnt - w0 < 30 && n < 3000) begin tick(); n++; end
    reset = 1'b1; tick(); reset = 1'b0;
    sb.delete();
    check("c_wr_count", wr_cnt - w0, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
